ram_4002: RTL and testbench

- Cycle-accurate model of one MCS-4 4002 RAM chip, consuming the nibble bus and CM-RAM line driven by the 4004 CPU core.
- Tracks the 8-phase instruction cycle (A1,A2,A3,M1,M2,X1,X2,X3) from SYNC.
- Captures the SRC address and executes I/O-RAM group commands against its storage:
  - 4 registers × 16 main characters;
  - 4 registers × 4 status characters;
  - 4-bit output port.
- Bank selection is done externally by gating cm_ram; this block handles chip select only.

---
 rtl/ram_4002.sv | 149 ++++++++++++++
 tb/tb_ram_4002.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ram_4002.sv
// MCS-4 4002 RAM chip: follows the 8-phase instruction cycle, latches SRC addresses and
// executes I/O-RAM commands against 4x16 main characters, 4x4 status characters and a port.
module ram_4002 #(
    parameter logic [1:0] Chip_addr = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       cm_ram,
    input  logic [3:0] d_in,
    output logic [3:0] d_out,
    output logic       d_oe,
    output logic [3:0] port_out
);

    typedef enum logic [2:0] {
        PhA1, PhA2, PhA3, PhM1, PhM2, PhX1, PhX2, PhX3
    } phase_e;

    phase_e     phase_q, phase_d;
    logic       synced_q, synced_d;
    logic       selected_q, selected_d;
    logic [1:0] reg_sel_q, reg_sel_d;
    logic [3:0] char_sel_q, char_sel_d;
    logic       src_pending_q, src_pending_d;
    logic       io_pending_q, io_pending_d;
    logic [3:0] io_op_q, io_op_d;
    logic [3:0] port_out_q, port_out_d;
    logic [3:0] d_out_q, d_out_d;
    logic       d_oe_q, d_oe_d;
    logic [3:0] main_q [64];
    logic [3:0] main_d [64];
    logic [3:0] status_q [16];
    logic [3:0] status_d [16];
    logic       resync;

    // sync outside X3 means the CPU slipped: realign and drop anything in flight
    assign resync = sync && (phase_q != PhX3);

    always_comb begin
        phase_d       = sync ? PhA1 : phase_e'(phase_q + 3'd1);
        synced_d      = synced_q | sync;
        selected_d    = selected_q;
        reg_sel_d     = reg_sel_q;
        char_sel_d    = char_sel_q;
        src_pending_d = src_pending_q;
        io_pending_d  = io_pending_q;
        io_op_d       = io_op_q;
        port_out_d    = port_out_q;
        d_out_d       = d_out_q;
        d_oe_d        = 1'b0;
        main_d        = main_q;
        status_d      = status_q;

        if (resync) begin
            src_pending_d = 1'b0;
            io_pending_d  = 1'b0;
        end else if (synced_q) begin
            unique case (phase_q)
                PhM2: begin
                    if (cm_ram) begin
                        if (selected_q) begin
                            io_op_d      = d_in;
                            io_pending_d = 1'b1;
                        end else begin
                            io_pending_d = 1'b0;
                        end
                    end
                end
                // Read data is registered here so it is on the bus for the whole of X2
                PhX1: begin
                    if (io_pending_q) begin
                        case (io_op_q)
                            4'h8, 4'h9, 4'hB: begin
                                d_out_d = main_q[{reg_sel_q, char_sel_q}];
                                d_oe_d  = 1'b1;
                            end
                            4'hC, 4'hD, 4'hE, 4'hF: begin
                                d_out_d = status_q[{reg_sel_q, io_op_q[1:0]}];
                                d_oe_d  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                PhX2: begin
                    if (cm_ram) begin
                        selected_d    = (d_in[3:2] == Chip_addr);
                        reg_sel_d     = d_in[1:0];
                        src_pending_d = 1'b1;
                    end
                    if (io_pending_q) begin
                        case (io_op_q)
                            4'h0:                   main_d[{reg_sel_q, char_sel_q}] = d_in;
                            4'h1:                   port_out_d = d_in;
                            4'h4, 4'h5, 4'h6, 4'h7: status_d[{reg_sel_q, io_op_q[1:0]}] = d_in;
                            default: ;
                        endcase
                    end
                end
                PhX3: begin
                    if (src_pending_q) begin
                        char_sel_d    = d_in;
                        src_pending_d = 1'b0;
                    end
                    io_pending_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PhA1;
            synced_q      <= 1'b0;
            selected_q    <= 1'b0;
            reg_sel_q     <= 2'd0;
            char_sel_q    <= 4'd0;
            src_pending_q <= 1'b0;
            io_pending_q  <= 1'b0;
            io_op_q       <= 4'd0;
            port_out_q    <= 4'd0;
            d_out_q       <= 4'd0;
            d_oe_q        <= 1'b0;
            main_q        <= '{default: 4'd0};
            status_q      <= '{default: 4'd0};
        end else begin
            phase_q       <= phase_d;
            synced_q      <= synced_d;
            selected_q    <= selected_d;
            reg_sel_q     <= reg_sel_d;
            char_sel_q    <= char_sel_d;
            src_pending_q <= src_pending_d;
            io_pending_q  <= io_pending_d;
            io_op_q       <= io_op_d;
            port_out_q    <= port_out_d;
            d_out_q       <= d_out_d;
            d_oe_q        <= d_oe_d;
            main_q        <= main_d;
            status_q      <= status_d;
        end
    end

    assign d_out    = d_out_q;
    assign d_oe     = d_oe_q;
    assign port_out = port_out_q;

endmodule

// File: tb/tb_ram_4002.sv
// Scoreboard bench for ram_4002: stimulus queues expected read nibbles, a negedge monitor
// pops one whenever the chip drives the bus and also checks that this happens only in X2.
module tb_ram_4002;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       cm_ram;
    logic [3:0] d_in;
    logic [3:0] d_out;
    logic       d_oe;
    logic [3:0] port_out;

    int         n_vec = 0;
    int         n_err = 0;
    int         tb_phase = 0;
    logic [3:0] exp_q [$];

    localparam int X2 = 6;

    ram_4002 #(.Chip_addr(2'd1)) dut (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .cm_ram   (cm_ram),
        .d_in     (d_in),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .port_out (port_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (d_oe === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: d_oe=1 d_out=%h phase=%0d, required d_oe=0",
                         d_out, tb_phase);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (tb_phase != X2 || d_out !== e) begin
                    n_err++;
                    $display("FAIL read_data: d_out=%h phase=%0d, required d_out=%h phase=%0d",
                             d_out, tb_phase, e, X2);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic c, input logic [3:0] d, input int ph);
        sync     = s;
        cm_ram   = c;
        d_in     = d;
        tb_phase = ph;
        @(posedge clk);
        #1;
    endtask

    // One instruction: A1..M1 idle, M2, X1, X2, X3 with sync
    task automatic instr(input logic cm_m2, input logic [3:0] d_m2, input logic cm_x2,
                         input logic [3:0] d_x2, input logic [3:0] d_x3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, i);
        step(1'b0, cm_m2, d_m2, 4);
        step(1'b0, 1'b0, 4'h0, 5);
        step(1'b0, cm_x2, d_x2, 6);
        step(1'b1, 1'b0, d_x3, 7);
    endtask

    task automatic src(input logic [3:0] hi, input logic [3:0] lo);
        instr(1'b0, 4'h0, 1'b1, hi, lo);
    endtask

    task automatic io(input logic [3:0] op, input logic [3:0] data);
        instr(1'b1, op, 1'b0, data, 4'h0);
    endtask

    initial begin
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0, 0);
        step(1'b0, 1'b0, 4'h0, 0);
        rst = 1'b0;
        chk("reset_d_oe", int'(d_oe), 0);
        chk("reset_port_out", int'(port_out), 0);
        chk("reset_d_out", int'(d_out), 0);
        step(1'b1, 1'b0, 4'h0, 7);

        for (int i = 0; i < 3; i++) instr(1'b0, 4'h0, 1'b0, 4'h0, 4'h0);
        chk("idle_port_out", int'(port_out), 0);

        // Not selected yet: WMP must be ignored
        io(4'h1, 4'h3);
        chk("unselected_wmp", int'(port_out), 0);

        src(4'b0110, 4'hA);
        io(4'h0, 4'h7);
        exp_q.push_back(4'h7);
        io(4'h9, 4'h0);
        exp_q.push_back(4'h7);
        io(4'hB, 4'h0);

        src(4'b0110, 4'hB);
        exp_q.push_back(4'h0);
        io(4'h8, 4'h0);

        io(4'h1, 4'h5);
        chk("wmp_port_out", int'(port_out), 5);

        src(4'b1100, 4'h0);
        io(4'h1, 4'h9);
        chk("other_chip_wmp", int'(port_out), 5);
        io(4'h9, 4'h0);

        src(4'b0101, 4'h0);
        io(4'h6, 4'hC);
        exp_q.push_back(4'hC);
        io(4'hE, 4'h0);
        exp_q.push_back(4'h0);
        io(4'hC, 4'h0);
        exp_q.push_back(4'h0);
        io(4'h9, 4'h0);

        io(4'h2, 4'h4);
        io(4'hA, 4'h0);
        io(4'h3, 4'h8);
        exp_q.push_back(4'hC);
        io(4'hE, 4'h0);
        chk("rom_ops_port_out", int'(port_out), 5);

        // SRC in X2 overlapping a pending WR1 in reg 1; the write uses the old reg_sel
        instr(1'b1, 4'h5, 1'b1, 4'b0110, 4'hA);
        src(4'b0101, 4'h0);
        exp_q.push_back(4'h6);
        io(4'hD, 4'h0);

        // WMP abandoned by sync landing in X1
        src(4'b0110, 4'hA);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, i);
        step(1'b0, 1'b1, 4'h1, 4);
        step(1'b1, 1'b0, 4'h0, 5);
        instr(1'b0, 4'h0, 1'b0, 4'hF, 4'h0);
        chk("resync_drops_wmp", int'(port_out), 5);

        // Sync at M1, then realigned read
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, i);
        step(1'b1, 1'b0, 4'h0, 3);
        exp_q.push_back(4'h7);
        io(4'h9, 4'h0);

        // Reset during X2 of an RDM
        exp_q.push_back(4'h7);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, i);
        step(1'b0, 1'b1, 4'h9, 4);
        step(1'b0, 1'b0, 4'h0, 5);
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0, 6);
        rst = 1'b0;
        chk("rst_release_d_oe", int'(d_oe), 0);
        chk("rst_port_out", int'(port_out), 0);
        step(1'b1, 1'b0, 4'h0, 7);
        src(4'b0110, 4'hA);
        exp_q.push_back(4'h0);
        io(4'h9, 4'h0);
        src(4'b0101, 4'h0);
        exp_q.push_back(4'h0);
        io(4'hE, 4'h0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
